// File: rtl/qpu_exu_alu_arbt_pkg.sv
// Shared QPU definitions for the ALU arbiter: operand width,
// requester indices and arbiter state encodings.
package qpu_exu_alu_arbt_pkg;

   localparam int QPU_XLEN = 32;
   localparam int NREQ     = 4;

   typedef enum logic [1:0] {
      REQ_ALU = 2'd0,
      REQ_BJP = 2'd1,
      REQ_LSU = 2'd2,
      REQ_QIU = 2'd3
   } req_idx_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arbt_st_e;

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      unique case (1'b1)
         oh[0]:   idx = REQ_ALU;
         oh[1]:   idx = REQ_BJP;
         oh[2]:   idx = REQ_LSU;
         oh[3]:   idx = REQ_QIU;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/qpu_exu_alu_arbt_pick.sv
// Combinational winner picker: round-robin from ptr+1, or
// lowest-index-wins when RR_EN is 0.
module qpu_exu_rr_pick
   import qpu_exu_alu_arbt_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] win
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      win   = 4'b0000;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 0; i < NREQ; i++) begin
         idx = RR_EN ? (ptr + 2'(i) + 2'd1) : 2'(i);
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/qpu_exu_alu_arbt.sv
// Shared-ALU arbiter: grants one of four requesters per cycle and
// holds the registered result until its owner accepts it.
module qpu_exu_alu_arbt
   import qpu_exu_alu_arbt_pkg::*;
#(
   parameter int XLEN  = QPU_XLEN,
   parameter bit RR_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req_vld,
   output logic [3:0]      req_rdy,
   output logic [3:0]      dpath_req,
   input  logic [XLEN-1:0] dpath_res,
   input  logic            dpath_cmp,
   output logic [3:0]      rsp_vld,
   input  logic [3:0]      rsp_rdy,
   output logic [XLEN-1:0] rsp_res,
   output logic            rsp_cmp,
   input  logic            flush
);

   arbt_st_e   state;
   arbt_st_e   state_nxt;
   logic [1:0] owner;
   logic [1:0] ptr;
   logic [3:0] win;
   logic [3:0] gnt;
   logic       rsp_acc;
   logic       grant_ok;

   qpu_exu_rr_pick #(
      .RR_EN (RR_EN)
   ) u_pick (
      .req (req_vld),
      .ptr (ptr),
      .win (win)
   );

   assign rsp_acc  = rsp_rdy[owner];
   assign grant_ok = !flush && (state == ST_EMPTY || rsp_acc);
   assign gnt      = grant_ok ? win : 4'b0000;

   assign req_rdy   = gnt;
   assign dpath_req = gnt;
   assign rsp_vld   = (state == ST_FULL) ? (4'b0001 << owner) : 4'b0000;

   always_comb begin
      state_nxt = state;
      if (flush)
         state_nxt = ST_EMPTY;
      else if (|gnt)
         state_nxt = ST_FULL;
      else if (state == ST_FULL && rsp_acc)
         state_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   // ptr only moves on a real grant, so flush leaves it untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner   <= REQ_ALU;
         ptr     <= REQ_QIU;
         rsp_res <= '0;
         rsp_cmp <= 1'b0;
      end else if (|gnt) begin
         owner   <= oh2idx(gnt);
         ptr     <= oh2idx(gnt);
         rsp_res <= dpath_res;
         rsp_cmp <= dpath_cmp;
      end
   end

endmodule

// File: tb/tb_qpu_exu_alu_arbt.sv
// Randomized bench for qpu_exu_alu_arbt: round-robin and fixed-priority
// instances against a behavioural model, plus directed literal cases.
module tb_qpu_exu_alu_arbt;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [3:0]      req_vld;
   logic [3:0]      rsp_rdy;
   logic [XLEN-1:0] dpath_res;
   logic            dpath_cmp;
   logic            flush;

   logic [3:0]      rr_req_rdy, rr_dpath_req, rr_rsp_vld;
   logic [XLEN-1:0] rr_rsp_res;
   logic            rr_rsp_cmp;
   logic [3:0]      fp_req_rdy, fp_dpath_req, fp_rsp_vld;
   logic [XLEN-1:0] fp_rsp_res;
   logic            fp_rsp_cmp;

   int checks = 0;
   int errors = 0;

   // model state, index 0 = round-robin instance, 1 = fixed priority
   bit          m_full [2];
   int          m_own  [2];
   int          m_ptr  [2];
   logic [31:0] m_res  [2];
   logic        m_cmp  [2];

   always #5 clk = ~clk;

   qpu_exu_alu_arbt #(.XLEN(XLEN), .RR_EN(1'b1)) dut_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_vld   (req_vld),
      .req_rdy   (rr_req_rdy),
      .dpath_req (rr_dpath_req),
      .dpath_res (dpath_res),
      .dpath_cmp (dpath_cmp),
      .rsp_vld   (rr_rsp_vld),
      .rsp_rdy   (rsp_rdy),
      .rsp_res   (rr_rsp_res),
      .rsp_cmp   (rr_rsp_cmp),
      .flush     (flush)
   );

   qpu_exu_alu_arbt #(.XLEN(XLEN), .RR_EN(1'b0)) dut_fp (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_vld   (req_vld),
      .req_rdy   (fp_req_rdy),
      .dpath_req (fp_dpath_req),
      .dpath_res (dpath_res),
      .dpath_cmp (dpath_cmp),
      .rsp_vld   (fp_rsp_vld),
      .rsp_rdy   (rsp_rdy),
      .rsp_res   (fp_rsp_res),
      .rsp_cmp   (fp_rsp_cmp),
      .flush     (flush)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic int winner(input int k);
      if (req_vld == 4'b0000) return -1;
      if (k == 0) begin
         for (int i = 1; i <= 4; i++)
            if (req_vld[(m_ptr[0] + i) % 4]) return (m_ptr[0] + i) % 4;
      end else begin
         for (int j = 0; j < 4; j++)
            if (req_vld[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_gnt(input int k);
      bit ok;
      int w;
      ok = !flush && (!m_full[k] || rsp_rdy[m_own[k]]);
      w  = winner(k);
      if (ok && w >= 0) return 4'(1 << w);
      return 4'b0000;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_full[k] = 0;
         m_own[k]  = 0;
         m_ptr[k]  = 3;
         m_res[k]  = '0;
         m_cmp[k]  = 1'b0;
      end
   endtask

   task automatic cmp_inst(input int k, input string t,
                           input logic [3:0] rdy, input logic [3:0] dq,
                           input logic [3:0] rv, input logic [31:0] rs,
                           input logic rc);
      logic [3:0] ev;
      ev = m_full[k] ? 4'(1 << m_own[k]) : 4'b0000;
      chk({t, "_req_rdy"}, 32'(rdy), 32'(exp_gnt(k)));
      chk({t, "_dpath_req"}, 32'(dq), 32'(exp_gnt(k)));
      chk({t, "_rsp_vld"}, 32'(rv), 32'(ev));
      chk({t, "_rsp_res"}, rs, m_res[k]);
      chk({t, "_rsp_cmp"}, 32'(rc), 32'(m_cmp[k]));
   endtask

   // compare at negedge, then advance model across the next posedge
   task automatic cyc();
      logic [3:0] g [2];
      @(negedge clk);
      cmp_inst(0, "rr", rr_req_rdy, rr_dpath_req, rr_rsp_vld,
               rr_rsp_res, rr_rsp_cmp);
      cmp_inst(1, "fp", fp_req_rdy, fp_dpath_req, fp_rsp_vld,
               fp_rsp_res, fp_rsp_cmp);
      for (int k = 0; k < 2; k++) g[k] = exp_gnt(k);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (flush) begin
            m_full[k] = 0;
         end else if (g[k] != 4'b0000) begin
            m_full[k] = 1;
            for (int j = 0; j < 4; j++)
               if (g[k][j]) begin
                  m_own[k] = j;
                  m_ptr[k] = j;
               end
            m_res[k] = dpath_res;
            m_cmp[k] = dpath_cmp;
         end else if (m_full[k] && rsp_rdy[m_own[k]]) begin
            m_full[k] = 0;
         end
      end
      #1;
   endtask

   task automatic drive(input logic [3:0] rv, input logic [3:0] rr,
                        input logic fl, input logic [31:0] res);
      req_vld   = rv;
      rsp_rdy   = rr;
      flush     = fl;
      dpath_res = res;
      dpath_cmp = res[0];
      #2;
   endtask

   initial begin
      logic [3:0] seq [5];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_n = 1'b0;
      model_reset();
      drive(4'b0000, 4'b0000, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("reset_rsp_vld", 32'(rr_rsp_vld), 32'h0);
      chk("reset_rsp_res", rr_rsp_res, 32'h0);
      chk("reset_rsp_cmp", 32'(rr_rsp_cmp), 32'h0);

      // round-robin fairness from reset pointer
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 4'b1111, 1'b0, 32'(i + 16));
         chk($sformatf("rr_fair%0d", i), 32'(rr_req_rdy), 32'(seq[i]));
         chk($sformatf("fp_fair%0d", i), 32'(fp_req_rdy), 32'h1);
         cyc();
      end
      drive(4'b0000, 4'b1111, 1'b0, 32'h0);
      cyc();

      // single request
      drive(4'b0100, 4'b0000, 1'b0, 32'h0000_1234);
      chk("single_req_rdy", 32'(rr_req_rdy), 32'h4);
      chk("single_dpath", 32'(rr_dpath_req), 32'h4);
      cyc();
      drive(4'b0000, 4'b0000, 1'b0, 32'h0);
      chk("single_rsp_vld", 32'(rr_rsp_vld), 32'h4);
      chk("single_rsp_res", rr_rsp_res, 32'h1234);
      cyc();

      // backpressure on owner 1
      drive(4'b0010, 4'b0100, 1'b0, 32'hBEEF);
      cyc();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0001, 4'b1101, 1'b0, 32'h5555);
         chk($sformatf("bp_rdy%0d", i), 32'(rr_req_rdy), 32'h0);
         chk($sformatf("bp_res%0d", i), rr_rsp_res, 32'hBEEF);
         cyc();
      end
      drive(4'b0001, 4'b0010, 1'b0, 32'h6666);
      chk("bp_release", 32'(rr_req_rdy), 32'h1);
      cyc();

      // fixed priority
      for (int i = 0; i < 4; i++) begin
         drive(4'b1010, 4'b1111, 1'b0, 32'(i));
         chk($sformatf("fp_pri%0d", i), 32'(fp_req_rdy), 32'h2);
         cyc();
      end

      // flush while owner 2 holds
      drive(4'b0100, 4'b1111, 1'b0, 32'h7777);
      cyc();
      drive(4'b0001, 4'b0000, 1'b1, 32'h8888);
      chk("flush_rdy", 32'(rr_req_rdy), 32'h0);
      cyc();
      drive(4'b0001, 4'b0000, 1'b0, 32'h9999);
      chk("flush_rsp_vld", 32'(rr_rsp_vld), 32'h0);
      chk("flush_regrant", 32'(rr_req_rdy), 32'h1);
      cyc();

      // asynchronous reset while full
      drive(4'b1111, 4'b0000, 1'b0, 32'hAAAA);
      cyc();
      drive(4'b0000, 4'b0000, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("areset_rr_vld", 32'(rr_rsp_vld), 32'h0);
      chk("areset_fp_vld", 32'(fp_rsp_vld), 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(4'b1111, 4'b0000, 1'b0, 32'hCCCC);
      chk("areset_first", 32'(rr_req_rdy), 32'h1);
      cyc();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 15) == 0), $urandom);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qpu_exu_alu_arbt.md
QPU_EXU_ALU_ARBT -- requirements
Module: QPU_exu_alu_arbt

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, default `QPU_XLEN, operand/result width.
- RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority.
REQ-002 Ports SHALL be, one per line (requester index: 0=ALU, 1=BJP, 2=LSU, 3=QIU):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  4  per-requester request valid.
- req_rdy  out  4  per-requester request accepted (grant).
- dpath_req  out  4  one-hot select to datapath alu/bjp/lsu/qiu_req_alu.
- dpath_res  in  XLEN  datapath arithmetic/logic result.
- dpath_cmp  in  1  datapath compare result.
- rsp_vld  out  4  per-requester response valid.
- rsp_rdy  in  4  per-requester response accept.
- rsp_res  out  XLEN  registered result.
- rsp_cmp  out  1  registered compare result.
- flush  in  1  synchronous drop of held response and grant.
REQ-003 Clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low; no other clock or reset.

Function
REQ-004 State SHALL be two-valued: EMPTY (no held response) and FULL (response held for owner).
REQ-005 Grant SHALL be allowed in a cycle iff flush=0 and (state=EMPTY, or state=FULL and rsp_rdy[owner]=1).
REQ-006 When grant is allowed and req_vld!=0, exactly one winner w SHALL be chosen combinationally; req_rdy=onehot(w), dpath_req=onehot(w), same cycle.
REQ-007 When no grant occurs, req_rdy and dpath_req SHALL be 4'b0000.
REQ-008 RR_EN=1: search SHALL start at index (last_winner+1) mod 4 and wrap; pointer SHALL update only on a grant.
REQ-009 RR_EN=0: the lowest set index SHALL win.
REQ-010 On a grant, the next edge SHALL capture dpath_res into rsp_res, dpath_cmp into rsp_cmp, w into owner, and set state=FULL; latency request-to-response is 1 cycle.
REQ-011 In FULL, rsp_vld SHALL equal onehot(owner); rsp_res/rsp_cmp SHALL hold stable until the response is accepted.
REQ-012 In FULL with rsp_rdy[owner]=1 and no grant, state SHALL go EMPTY; with a simultaneous grant, state SHALL stay FULL with new data/owner (throughput 1 op/cycle).
REQ-013 rsp_rdy bits of non-owners SHALL be ignored.
REQ-014 flush=1 SHALL force req_rdy=0 and dpath_req=0, and at the next edge state=EMPTY; the RR pointer SHALL be unchanged.
REQ-015 In EMPTY, rsp_vld SHALL be 4'b0000; rsp_res/rsp_cmp SHALL retain their last value.

Reset
REQ-016 On rst_n=0, regardless of clk: state=EMPTY, owner=0, RR pointer=3 (so index 0 is searched first), rsp_res=0, rsp_cmp=0.
REQ-017 Reset mid-operation SHALL discard any held response; no rsp_vld SHALL assert before a new grant.

Structure
REQ-018 Requester index encodings (0..3) and state encodings SHALL live in the shared QPU defines file alongside `QPU_XLEN.
REQ-019 The round-robin/priority picker SHALL be one sub-module, QPU_exu_rr_pick (inputs: 4-bit request, pointer, RR_EN; output: one-hot winner). It is purely combinational; all state stays in QPU_exu_alu_arbt.

Verification
REQ-020 Single request: req_vld=4'b0100, dpath_res=32'h0000_1234 -> same-cycle req_rdy=dpath_req=4'b0100; next cycle rsp_vld=4'b0100, rsp_res=32'h1234.
REQ-021 Round-robin fairness: RR_EN=1, req_vld=4'b1111 held, rsp_rdy=4'b1111 -> grants 0,1,2,3,0 on consecutive cycles, one rsp_vld per cycle.
REQ-022 Backpressure: owner 1 with rsp_rdy[1]=0 for 3 cycles and req_vld=4'b0001 -> req_rdy=0 and rsp_res stable for those 3 cycles; grant to 0 in the cycle rsp_rdy[1]=1.
REQ-023 Fixed priority: RR_EN=0, req_vld=4'b1010 held, rsp_rdy=4'b1111 -> index 1 is granted every cycle; index 3 is never granted.
REQ-024 Flush: state FULL owner 2, flush=1, req_vld=4'b0001 -> req_rdy=0 that cycle; rsp_vld=0 next cycle; grant to 0 the cycle after.
REQ-025 Async reset: assert rst_n=0 between clk edges while FULL -> rsp_vld=0 immediately; after release, req_vld=4'b1111 grants index 0 first.
